// File: rtl/pe_group_accum_pkg.sv
// Shared types and default constants for the grouped lane accumulator.
// Holds the FSM state encoding and the select-width helper.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_LANES = 8;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 2;

  function automatic int sel_width(input int ngroups);
    return (ngroups > 1) ? $clog2(ngroups) : 1;
  endfunction

endpackage

// File: rtl/pe_group_accum_if.sv
// Input-beat / frame-result handshake bundle for pe_group_accum.
// Width parameters must match the ones given to the attached accumulator.
interface pe_group_accum_if #(
  parameter int LANES = pe_pkg::DEF_LANES,
  parameter int WIDTH = pe_pkg::DEF_WIDTH,
  parameter int GROUP = pe_pkg::DEF_GROUP
);

  localparam int NGROUPS = LANES / GROUP;
  localparam int SELW    = pe_pkg::sel_width(NGROUPS);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] data;
  logic [SELW-1:0]        sel;
  logic [7:0]             acc_len;
  logic                   out_valid;
  logic                   out_ready;
  logic [GROUP*WIDTH-1:0] ACC_DATA;
  logic [GROUP-1:0]       ovf;

  modport master (
    output in_valid, data, sel, acc_len, out_ready,
    input  in_ready, out_valid, ACC_DATA, ovf
  );

  modport slave (
    input  in_valid, data, sel, acc_len, out_ready,
    output in_ready, out_valid, ACC_DATA, ovf
  );

endinterface

// File: rtl/pe_group_accum_sel.sv
// Picks GROUP adjacent lanes out of a LANES-wide vector by group index.
// An index past the last group yields all-zero lanes.
module pe_group_sel #(
  parameter int LANES = pe_pkg::DEF_LANES,
  parameter int WIDTH = pe_pkg::DEF_WIDTH,
  parameter int GROUP = pe_pkg::DEF_GROUP,
  parameter int SELW  = 1
) (
  input  logic [LANES-1:0][WIDTH-1:0] data,
  input  logic [SELW-1:0]             sel,
  output logic [GROUP-1:0][WIDTH-1:0] grp
);

  localparam int NGROUPS = LANES / GROUP;

  // NOTE: grp gets a full default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grp = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      if (int'(sel) == g) begin
        for (int i = 0; i < GROUP; i++) begin
          grp[i] = data[g*GROUP + i];
        end
      end
    end
  end

endmodule

// File: rtl/pe_group_accum.sv
// Frame accumulator: sums one selectable lane group per accepted beat over
// acc_len beats, then presents the per-lane sums and sticky carries.
module pe_group_accum
  import pe_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input logic              CLK,
  input logic              RST,
  pe_group_accum_if.slave  bus
);

  localparam int NGROUPS = LANES / GROUP;
  localparam int SELW    = sel_width(NGROUPS);

  if (GROUP < 1 || (LANES % GROUP) != 0) begin : g_bad_cfg
    $error("pe_group_accum: LANES must be a multiple of GROUP and GROUP >= 1");
  end

  state_t                   state_q, state_d;
  logic [GROUP-1:0][WIDTH-1:0] acc_q, grp, sum;
  logic [GROUP-1:0]         ovf_q, carry;
  logic [7:0]               len_q, cnt_q, len_in;
  logic                     ready, accept, first, last;

  pe_group_sel #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .GROUP (GROUP),
    .SELW  (SELW)
  ) u_sel (
    .data (bus.data),
    .sel  (bus.sel),
    .grp  (grp)
  );

  assign ready  = (state_q != DONE) | bus.out_ready;
  assign accept = bus.in_valid & ready;
  // Any beat accepted outside ACCUM opens a new frame, including the DONE hand-over.
  assign first  = accept & (state_q != ACCUM);
  assign last   = accept & (state_q == ACCUM) & ((cnt_q + 8'd1) == len_q);
  assign len_in = (bus.acc_len == 8'd0) ? 8'd1 : bus.acc_len;

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.ACC_DATA  = acc_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = (len_in == 8'd1) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = (len_in == 8'd1) ? DONE : ACCUM;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    sum   = '0;
    carry = '0;
    for (int i = 0; i < GROUP; i++) begin
      {carry[i], sum[i]} = {1'b0, acc_q[i]} + {1'b0, grp[i]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc_q <= '0;
      ovf_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (first) begin
      acc_q <= grp;
      ovf_q <= '0;
      len_q <= len_in;
      cnt_q <= 8'd1;
    end else if (accept) begin
      acc_q <= sum;
      ovf_q <= ovf_q | carry;
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_pe_group_accum.sv
// Directed bench for pe_group_accum: frame table plus hand-written
// back-pressure, hand-over, reset-abort and out-of-range-select sequences.
module tb_pe_group_accum;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  pe_group_accum_if #(.LANES(8), .WIDTH(32), .GROUP(2)) b8();
  pe_group_accum_if #(.LANES(6), .WIDTH(32), .GROUP(2)) b6();

  pe_group_accum #(.LANES(8), .WIDTH(32), .GROUP(2)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (b8)
  );

  pe_group_accum #(.LANES(6), .WIDTH(32), .GROUP(2)) dut6 (
    .CLK (CLK),
    .RST (RST),
    .bus (b6)
  );

  typedef struct {
    logic [7:0]  acc_len;
    int          nb;
    logic [1:0]  s [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eovf;
  } vec_t;

  vec_t vt [5];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Lanes default to index+1; the chosen group's two lanes are overridden.
  function automatic logic [255:0] mk8(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(i + 1);
    d[int'(s)*64 +: 32]      = a;
    d[int'(s)*64 + 32 +: 32] = b;
    return d;
  endfunction

  function automatic logic [191:0] mk6(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [191:0] d;
    for (int i = 0; i < 6; i++) d[i*32 +: 32] = 32'(i + 1);
    if (s < 2'd3) begin
      d[int'(s)*64 +: 32]      = a;
      d[int'(s)*64 + 32 +: 32] = b;
    end
    return d;
  endfunction

  task automatic drive8(input logic [7:0] len, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    b8.in_valid = 1'b1;
    b8.acc_len  = len;
    b8.sel      = s;
    b8.data     = mk8(s, a, b);
  endtask

  task automatic run_vec(input int k);
    for (int j = 0; j < vt[k].nb; j++) begin
      // acc_len is scrambled after the first beat; the latched length must win.
      drive8((j == 0) ? vt[k].acc_len : (vt[k].acc_len ^ 8'h5A), vt[k].s[j], vt[k].a[j], vt[k].b[j]);
      #1;
      check($sformatf("v%0d b%0d in_ready", k, j), 64'(b8.in_ready), 64'd1);
      step();
      check($sformatf("v%0d b%0d out_valid", k, j), 64'(b8.out_valid), (j == vt[k].nb - 1) ? 64'd1 : 64'd0);
    end
    b8.in_valid = 1'b0;
    check($sformatf("v%0d acc", k), 64'(b8.ACC_DATA), {vt[k].e1, vt[k].e0});
    check($sformatf("v%0d ovf", k), 64'(b8.ovf), 64'(vt[k].eovf));
    step();
    check($sformatf("v%0d hold valid", k), 64'(b8.out_valid), 64'd1);
    check($sformatf("v%0d hold acc", k), 64'(b8.ACC_DATA), {vt[k].e1, vt[k].e0});
    b8.out_ready = 1'b1;
    step();
    check($sformatf("v%0d retired", k), 64'(b8.out_valid), 64'd0);
    b8.out_ready = 1'b0;
  endtask

  initial begin
    b8.in_valid = 1'b0; b8.data = '0; b8.sel = '0; b8.acc_len = '0; b8.out_ready = 1'b0;
    b6.in_valid = 1'b0; b6.data = '0; b6.sel = '0; b6.acc_len = '0; b6.out_ready = 1'b0;

    vt[0].acc_len = 8'd1; vt[0].nb = 1;
    vt[0].s = '{2'd2, 2'd0, 2'd0, 2'd0};
    vt[0].a = '{32'd5, 32'd0, 32'd0, 32'd0};
    vt[0].b = '{32'd6, 32'd0, 32'd0, 32'd0};
    vt[0].e0 = 32'd5; vt[0].e1 = 32'd6; vt[0].eovf = 2'b00;

    vt[1].acc_len = 8'd3; vt[1].nb = 3;
    vt[1].s = '{2'd0, 2'd1, 2'd3, 2'd0};
    vt[1].a = '{32'd1, 32'd3, 32'd7, 32'd0};
    vt[1].b = '{32'd2, 32'd4, 32'd8, 32'd0};
    vt[1].e0 = 32'd11; vt[1].e1 = 32'd14; vt[1].eovf = 2'b00;

    vt[2].acc_len = 8'd2; vt[2].nb = 2;
    vt[2].s = '{2'd0, 2'd0, 2'd0, 2'd0};
    vt[2].a = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
    vt[2].b = '{32'd0, 32'd0, 32'd0, 32'd0};
    vt[2].e0 = 32'd1; vt[2].e1 = 32'd0; vt[2].eovf = 2'b01;

    vt[3].acc_len = 8'd0; vt[3].nb = 1;
    vt[3].s = '{2'd1, 2'd0, 2'd0, 2'd0};
    vt[3].a = '{32'd3, 32'd0, 32'd0, 32'd0};
    vt[3].b = '{32'd4, 32'd0, 32'd0, 32'd0};
    vt[3].e0 = 32'd3; vt[3].e1 = 32'd4; vt[3].eovf = 2'b00;

    vt[4].acc_len = 8'd4; vt[4].nb = 4;
    vt[4].s = '{2'd3, 2'd1, 2'd0, 2'd2};
    vt[4].a = '{32'd0, 32'd0, 32'd5, 32'd1};
    vt[4].b = '{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd1};
    vt[4].e0 = 32'd6; vt[4].e1 = 32'd1; vt[4].eovf = 2'b10;

    step();
    step();
    check("reset out_valid", 64'(b8.out_valid), 64'd0);
    check("reset acc", 64'(b8.ACC_DATA), 64'd0);
    check("reset ovf", 64'(b8.ovf), 64'd0);
    check("reset in_ready", 64'(b8.in_ready), 64'd1);
    RST = 1'b1;
    step();

    for (int k = 0; k < 5; k++) run_vec(k);

    // Back-pressure in DONE, then retire and start a new frame on the same edge.
    drive8(8'd1, 2'd0, 32'd9, 32'd10);
    step();
    drive8(8'd2, 2'd1, 32'd3, 32'd4);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d in_ready", i), 64'(b8.in_ready), 64'd0);
      check($sformatf("bp%0d out_valid", i), 64'(b8.out_valid), 64'd1);
      check($sformatf("bp%0d acc", i), 64'(b8.ACC_DATA), {32'd10, 32'd9});
      step();
    end
    b8.out_ready = 1'b1;
    #1;
    check("handoff in_ready", 64'(b8.in_ready), 64'd1);
    step();
    check("handoff out_valid", 64'(b8.out_valid), 64'd0);
    check("handoff first beat", 64'(b8.ACC_DATA), {32'd4, 32'd3});
    b8.out_ready = 1'b0;
    drive8(8'h77, 2'd0, 32'd1, 32'd1);
    step();
    check("handoff done", 64'(b8.out_valid), 64'd1);
    check("handoff acc", 64'(b8.ACC_DATA), {32'd5, 32'd4});
    b8.out_ready = 1'b1;
    drive8(8'd1, 2'd2, 32'd5, 32'd6);
    step();
    check("done2done valid", 64'(b8.out_valid), 64'd1);
    check("done2done acc", 64'(b8.ACC_DATA), {32'd6, 32'd5});
    b8.in_valid = 1'b0;
    step();
    check("done2idle", 64'(b8.out_valid), 64'd0);
    b8.out_ready = 1'b0;

    // Reset after two of four beats must drop the partial frame.
    drive8(8'd4, 2'd0, 32'd1, 32'd2);
    step();
    drive8(8'd4, 2'd1, 32'd3, 32'd4);
    step();
    b8.in_valid = 1'b0;
    RST = 1'b0;
    step();
    RST = 1'b1;
    #1;
    check("abort acc", 64'(b8.ACC_DATA), 64'd0);
    check("abort ovf", 64'(b8.ovf), 64'd0);
    check("abort in_ready", 64'(b8.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("abort idle%0d", i), 64'(b8.out_valid), 64'd0);
    end
    drive8(8'd1, 2'd0, 32'd1, 32'd2);
    step();
    b8.in_valid = 1'b0;
    check("post-abort valid", 64'(b8.out_valid), 64'd1);
    check("post-abort acc", 64'(b8.ACC_DATA), {32'd2, 32'd1});
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;

    // Six lanes, three groups: sel=3 adds zero but still counts.
    b6.in_valid = 1'b1;
    b6.acc_len  = 8'd2;
    b6.sel      = 2'd3;
    b6.data     = mk6(2'd3, 32'd0, 32'd0);
    step();
    check("l6 oob valid", 64'(b6.out_valid), 64'd0);
    check("l6 oob acc", 64'(b6.ACC_DATA), 64'd0);
    b6.sel  = 2'd2;
    b6.data = mk6(2'd2, 32'd5, 32'd6);
    step();
    b6.in_valid = 1'b0;
    check("l6 done", 64'(b6.out_valid), 64'd1);
    check("l6 acc", 64'(b6.ACC_DATA), {32'd6, 32'd5});
    check("l6 ovf", 64'(b6.ovf), 64'd0);
    b6.out_ready = 1'b1;
    step();
    check("l6 retired", 64'(b6.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_group_accum.md
PE_GROUP_ACCUM -- requirements
Module: pe_group_accum

Interface
REQ-001 SHALL have parameter LANES, default 8, number of input lanes.
REQ-002 SHALL have parameter WIDTH, default 32, bits per lane and per accumulator.
REQ-003 SHALL have parameter GROUP, default 2, lanes per selectable group; NGROUPS = LANES/GROUP, SELW = max(1, clog2(NGROUPS)).
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input beat offered.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port data  input  LANES x WIDTH  packed lane vector, lane 0 in LSBs.
REQ-009 SHALL have port sel  input  SELW  group index for this beat.
REQ-010 SHALL have port acc_len  input  8  beats per frame; sampled on the first beat only; 0 treated as 1.
REQ-011 SHALL have port out_valid  output  1  frame result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port ACC_DATA  output  GROUP x WIDTH  per-lane frame sums.
REQ-014 SHALL have port ovf  output  GROUP  per-lane sticky carry-out for the current frame.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = out_ready in DONE.
REQ-017 SHALL drive out_valid = 1 only in DONE; ACC_DATA and ovf held stable while out_valid=1 and out_ready=0.
REQ-018 Beat accepted = in_valid & in_ready; the selected group is lanes sel*GROUP .. sel*GROUP+GROUP-1.
REQ-019 SHALL contribute zero for a beat whose sel >= NGROUPS (beat still counted).
REQ-020 First beat of a frame (accepted in IDLE or DONE) SHALL load accumulators with the selected group, clear ovf, latch length L = max(acc_len,1), and set beat count to 1.
REQ-021 Subsequent beats in ACCUM SHALL add the selected group lane-wise, modulo 2^WIDTH, unsigned; carry-out of lane i SHALL set ovf[i] sticky.
REQ-022 When the accepted beat makes count == L, the FSM SHALL enter DONE the next cycle; out_valid rises exactly one cycle after the last beat is accepted.
REQ-023 L = 1: IDLE -> DONE directly on the single beat.
REQ-024 DONE with out_ready=1 and no input: -> IDLE next cycle.
REQ-025 DONE with out_ready=1 and in_valid=1: result retired and the beat starts a new frame in the same cycle (-> ACCUM, or -> DONE if the new L = 1); no bubble.
REQ-026 in_valid=0 in ACCUM SHALL hold all state; no timeout.
REQ-027 acc_len and sel changes mid-frame SHALL not affect L; sel is used per beat.
REQ-028 ACC_DATA SHALL reflect the accumulator register directly (registered output, no combinational path from data).

Reset
REQ-029 On RST=0 at a rising edge: state IDLE, accumulators 0, ovf 0, count 0, out_valid 0, ACC_DATA 0.
REQ-030 Reset mid-frame or in DONE SHALL discard the partial or pending result without emitting it; in_ready = 1 on the first cycle after RST returns to 1.

Structure
REQ-031 SHALL place the FSM state enum and the default parameter constants in shared package pe_pkg.
REQ-032 SHALL use one sub-module pe_group_sel (combinational LANES->GROUP selector with out-of-range zeroing), instantiated once.
REQ-033 SHALL elaborate-time assert that LANES % GROUP == 0 and GROUP >= 1.

Verification
REQ-034 Defaults, acc_len=1, data lanes = lane index+1, sel=2 -> out_valid next cycle, ACC_DATA = {6,5} (lane1=6, lane0=5), ovf=0.
REQ-035 acc_len=3, beats sel=0,1,3 with lanes = index+1 -> ACC_DATA lane0 = 1+3+7 = 11, lane1 = 2+4+8 = 14; out_valid one cycle after the third beat.
REQ-036 acc_len=2, lane0 = 0xFFFF_FFFF then 0x2 -> ACC_DATA lane0 = 0x1, ovf[0] = 1, ovf[1] = 0.
REQ-037 DONE with out_ready=0 for 5 cycles, then out_ready=1 together with in_valid=1 -> result held unchanged for 5 cycles, new frame first beat accepted on the handshake cycle.
REQ-038 RST=0 asserted after 2 of 4 beats -> no out_valid; next frame acc_len=1 sel=0 -> ACC_DATA = {2,1}.
REQ-039 LANES=6, GROUP=2, sel=3 beat in a 2-beat frame -> contributes zero and counts as a beat.
